alu_arb: RTL and testbench



---
 rtl/alu_arb_pkg.sv | 24 ++
 rtl/alu_arb_rr_arb.sv | 44 ++++
 rtl/alu_arb.sv | 123 ++++++++++++
 tb/tb_alu_arb.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared definitions for the ALU arbiter.
//   DW, CW      : datapath and ALU command widths
//   alu_op_e    : ALU command encodings
//   alu_req_t   : one requester's operation {cmd, a, b, sc}
package alu_arb_pkg;
  localparam int DW = 9;
  localparam int CW = 3;

  typedef enum logic [CW-1:0] {
    ADD = 3'b000,
    LSL = 3'b001,
    XOR = 3'b011,
    LSR = 3'b101,
    SUB = 3'b110,
    CMP = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic [CW-1:0] cmd;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          sc;
  } alu_req_t;
endpackage

// File: rtl/alu_arb_rr_arb.sv
// rr_arb: round-robin pointer plus one-hot grant selection.
//   clk, rst_n : clock, synchronous active-low reset
//   eligible   : requesters that may be granted this cycle
//   grant      : one-hot (or zero) grant vector
//   grant_idx  : index of the granted requester (rr_ptr when idle)
//   any_grant  : a grant is issued this cycle
module rr_arb #(
  parameter int NREQ = 2,
  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] eligible,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx,
  output logic            any_grant
);
  logic [IW-1:0] rr_ptr;

  // Search upward from rr_ptr with wrap; the first eligible requester wins.
  always_comb begin
    grant     = '0;
    grant_idx = rr_ptr;
    any_grant = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = int'(rr_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!any_grant && eligible[j]) begin
        any_grant = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = IW'(j);
      end
    end
  end

  // Pointer moves just past the winner so it has lowest priority next time.
  always_ff @(posedge clk) begin
    if (!rst_n)
      rr_ptr <= '0;
    else if (any_grant)
      rr_ptr <= (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + IW'(1);
  end
endmodule

// File: rtl/alu_arb.sv
// alu_arb: shares one combinational ALU between NREQ requesters.
//   req_*     : per-requester valid/ready request {cmd, a, b, sc}, packed flat
//   rsp_*     : per-requester registered result slot, held until rsp_ready
//   alu_*     : to/from the external ALU; inputs are zero when nobody is granted
//   stat_*    : grant / stall counters, present only with ALU_ARB_STATS_EN,
//               otherwise tied to zero
// DW/CW must match the package widths, since alu_req_t is sized from them.
module alu_arb
  import alu_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int DW   = alu_arb_pkg::DW,
  parameter int CW   = alu_arb_pkg::CW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*CW-1:0]   req_cmd,
  input  logic [NREQ*DW-1:0]   req_a,
  input  logic [NREQ*DW-1:0]   req_b,
  input  logic [NREQ-1:0]      req_sc,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [NREQ*DW-1:0]   rsp_rslt,
  output logic [NREQ-1:0]      rsp_flag,
  output logic [CW-1:0]        alu_cmd,
  output logic [DW-1:0]        alu_a,
  output logic [DW-1:0]        alu_b,
  output logic                 alu_sc,
  input  logic [DW-1:0]        alu_rslt,
  input  logic                 alu_flag,
  output logic [NREQ*16-1:0]   stat_grants,
  output logic [15:0]          stat_stalls
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  alu_req_t [NREQ-1:0]          req;
  logic     [NREQ-1:0]          slot_vld;
  logic     [NREQ-1:0][DW-1:0]  slot_rslt;
  logic     [NREQ-1:0]          slot_flag;
  logic     [NREQ-1:0]          eligible;
  logic     [NREQ-1:0]          grant;
  logic     [IW-1:0]            grant_idx;
  logic                         any_grant;
  alu_req_t                     sel;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign req[i] = '{cmd: req_cmd[i*CW +: CW],
                      a:   req_a[i*DW +: DW],
                      b:   req_b[i*DW +: DW],
                      sc:  req_sc[i]};
  end

  // A full slot being drained this cycle can take a new result.
  assign eligible = req_valid & (~slot_vld | rsp_ready);

  rr_arb #(.NREQ(NREQ)) u_rr_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .eligible (eligible),
    .grant    (grant),
    .grant_idx(grant_idx),
    .any_grant(any_grant)
  );

  // Idle cycles present ADD 0,0 so the ALU never sees stale or X operands.
  always_comb begin
    sel = '0;
    if (any_grant) sel = req[grant_idx];
  end

  assign req_ready = grant;
  assign alu_cmd   = sel.cmd;
  assign alu_a     = sel.a;
  assign alu_b     = sel.b;
  assign alu_sc    = sel.sc;

  for (genvar i = 0; i < NREQ; i++) begin : g_slot
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        slot_vld[i]  <= 1'b0;
        slot_rslt[i] <= '0;
        slot_flag[i] <= 1'b0;
      end else if (grant[i]) begin
        slot_vld[i]  <= 1'b1;
        slot_rslt[i] <= alu_rslt;
        slot_flag[i] <= alu_flag;
      end else if (rsp_ready[i]) begin
        slot_vld[i]  <= 1'b0;
      end
    end
  end

  assign rsp_valid = slot_vld;
  assign rsp_rslt  = slot_rslt;
  assign rsp_flag  = slot_flag;

`ifdef ALU_ARB_STATS_EN
  logic [NREQ-1:0][15:0] grant_cnt;
  logic [15:0]           stall_cnt;

  // A stall is any cycle where some requester asks and is not the winner.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++)
        if (grant[i] && grant_cnt[i] != 16'hFFFF)
          grant_cnt[i] <= grant_cnt[i] + 16'd1;
      if (|(req_valid & ~grant) && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign stat_grants = grant_cnt;
  assign stat_stalls = stall_cnt;
`else
  assign stat_grants = '0;
  assign stat_stalls = '0;
`endif
endmodule

// File: tb/tb_alu_arb.sv
module tb_alu_arb;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready, req_sc, rsp_valid, rsp_ready, rsp_flag;
  logic [5:0]  req_cmd;
  logic [17:0] req_a, req_b, rsp_rslt;
  logic [2:0]  alu_cmd;
  logic [8:0]  alu_a, alu_b, alu_rslt;
  logic        alu_sc, alu_flag;
  logic [31:0] stat_grants;
  logic [15:0] stat_stalls;

  int n_cmp = 0;
  int n_err = 0;
  logic [8:0] exp_q0[$];
  logic [8:0] exp_q1[$];
  logic [8:0] e, held;

  always #5 clk = ~clk;

  alu_arb #(.NREQ(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_a(req_a), .req_b(req_b), .req_sc(req_sc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rslt(rsp_rslt), .rsp_flag(rsp_flag),
    .alu_cmd(alu_cmd), .alu_a(alu_a), .alu_b(alu_b), .alu_sc(alu_sc),
    .alu_rslt(alu_rslt), .alu_flag(alu_flag),
    .stat_grants(stat_grants), .stat_stalls(stat_stalls)
  );

  // Behavioural ALU standing in for the shared one.
  always_comb begin
    case (alu_cmd)
      3'b001:  alu_rslt = alu_a << alu_b[3:0];
      3'b011:  alu_rslt = alu_a ^ alu_b;
      3'b101:  alu_rslt = alu_a >> alu_b[3:0];
      3'b110:  alu_rslt = alu_a - alu_b;
      3'b111:  alu_rslt = alu_a - alu_b;
      default: alu_rslt = alu_a + alu_b;
    endcase
    alu_flag = (alu_rslt == 9'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [2:0] c, input logic [8:0] a, input logic [8:0] b);
    req_cmd[i*3 +: 3] = c;
    req_a[i*9 +: 9]   = a;
    req_b[i*9 +: 9]   = b;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '0; rsp_ready = '0; req_sc = '0;
    req_cmd = '0; req_a = '0; req_b = '0;
    tick(); tick();
    n_cmp++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL rst_rsp_valid got=%b exp=00", rsp_valid); end
    n_cmp++; if (rsp_rslt !== 18'd0) begin n_err++; $display("FAIL rst_rsp_rslt got=%h exp=0", rsp_rslt); end
    n_cmp++; if (rsp_flag !== 2'b00) begin n_err++; $display("FAIL rst_rsp_flag got=%b exp=00", rsp_flag); end
    rst_n = 1'b1;
    tick();
    #3;
    n_cmp++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL idle_rsp_valid got=%b exp=00", rsp_valid); end
    n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL idle_req_ready got=%b exp=00", req_ready); end
    n_cmp++; if (alu_cmd !== 3'b000) begin n_err++; $display("FAIL idle_alu_cmd got=%b exp=000", alu_cmd); end
    n_cmp++; if (alu_a !== 9'd0 || alu_b !== 9'd0) begin n_err++; $display("FAIL idle_alu_ab got=%h/%h exp=0/0", alu_a, alu_b); end
    n_cmp++; if (stat_grants !== 32'd0 || stat_stalls !== 16'd0) begin n_err++; $display("FAIL rst_stats got=%h/%h exp=0/0", stat_grants, stat_stalls); end
  endtask

  task automatic test_single();
    tick();
    set_req(0, 3'b000, 9'd100, 9'd27);
    req_valid = 2'b01;
    #3;
    n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL single_ready got=%b exp=01", req_ready); end
    n_cmp++; if (alu_a !== 9'd100 || alu_b !== 9'd27) begin n_err++; $display("FAIL single_alu_ab got=%0d/%0d exp=100/27", alu_a, alu_b); end
    exp_q0.push_back(9'd127);
    tick();
    req_valid = 2'b00;
    n_cmp++; if (rsp_valid !== 2'b01) begin n_err++; $display("FAIL single_rsp_valid got=%b exp=01", rsp_valid); end
    e = exp_q0.pop_front();
    n_cmp++; if (rsp_rslt[8:0] !== e) begin n_err++; $display("FAIL single_rslt got=%0d exp=%0d", rsp_rslt[8:0], e); end
    rsp_ready = 2'b01;
    tick();
    n_cmp++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL single_drain got=%b exp=00", rsp_valid); end
    rsp_ready = 2'b00;
  endtask

  task automatic test_contention();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    set_req(0, 3'b011, 9'h1FF, 9'h0F0);
    set_req(1, 3'b110, 9'd5, 9'd3);
    req_valid = 2'b11; rsp_ready = 2'b11;
    for (int c = 0; c < 4; c++) begin
      #3;
      n_cmp++;
      if (req_ready !== ((c % 2 == 0) ? 2'b01 : 2'b10)) begin
        n_err++; $display("FAIL contend_grant cyc=%0d got=%b exp=%b", c, req_ready, (c % 2 == 0) ? 2'b01 : 2'b10);
      end
      if (c % 2 == 0) exp_q0.push_back(9'h10F); else exp_q1.push_back(9'd2);
      tick();
      n_cmp++; if (rsp_valid[c % 2] !== 1'b1) begin n_err++; $display("FAIL contend_valid cyc=%0d got=%b", c, rsp_valid); end
      if (c % 2 == 0) begin
        e = exp_q0.pop_front();
        n_cmp++; if (rsp_rslt[8:0] !== e) begin n_err++; $display("FAIL contend_rslt0 got=%h exp=%h", rsp_rslt[8:0], e); end
      end else begin
        e = exp_q1.pop_front();
        n_cmp++; if (rsp_rslt[17:9] !== e) begin n_err++; $display("FAIL contend_rslt1 got=%h exp=%h", rsp_rslt[17:9], e); end
      end
    end
  endtask

  task automatic test_backpressure();
    rsp_ready = 2'b10;
    #3;
    n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL bp_fill got=%b exp=01", req_ready); end
    exp_q0.push_back(9'h10F);
    tick();
    held = exp_q0.pop_front();
    n_cmp++; if (rsp_rslt[8:0] !== held) begin n_err++; $display("FAIL bp_fill_rslt got=%h exp=%h", rsp_rslt[8:0], held); end
    for (int c = 0; c < 3; c++) begin
      set_req(1, 3'b000, 9'(c + 10), 9'd1);
      #3;
      n_cmp++; if (req_ready !== 2'b10) begin n_err++; $display("FAIL bp_grant cyc=%0d got=%b exp=10", c, req_ready); end
      exp_q1.push_back(9'(c + 11));
      tick();
      n_cmp++; if (rsp_valid[0] !== 1'b1 || rsp_rslt[8:0] !== held) begin
        n_err++; $display("FAIL bp_hold cyc=%0d got=%b/%h exp=1/%h", c, rsp_valid[0], rsp_rslt[8:0], held);
      end
      e = exp_q1.pop_front();
      n_cmp++; if (rsp_rslt[17:9] !== e) begin n_err++; $display("FAIL bp_rslt1 cyc=%0d got=%0d exp=%0d", c, rsp_rslt[17:9], e); end
    end
    rsp_ready = 2'b11;
    set_req(0, 3'b000, 9'd1, 9'd2);
    #3;
    n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL bp_refill got=%b exp=01", req_ready); end
    exp_q0.push_back(9'd3);
    tick();
    n_cmp++; if (rsp_valid !== 2'b01) begin n_err++; $display("FAIL bp_refill_valid got=%b exp=01", rsp_valid); end
    e = exp_q0.pop_front();
    n_cmp++; if (rsp_rslt[8:0] !== e) begin n_err++; $display("FAIL bp_refill_rslt got=%0d exp=%0d", rsp_rslt[8:0], e); end
  endtask

  task automatic test_reset_mid();
    #3;
    n_cmp++; if (req_ready !== 2'b10) begin n_err++; $display("FAIL mid_pre_grant got=%b exp=10", req_ready); end
    rst_n = 1'b0;
    tick();
    n_cmp++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL mid_rsp_valid got=%b exp=00", rsp_valid); end
    n_cmp++; if (rsp_rslt !== 18'd0) begin n_err++; $display("FAIL mid_rsp_rslt got=%h exp=0", rsp_rslt); end
    rst_n = 1'b1;
    #3;
    n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL mid_ptr got=%b exp=01", req_ready); end
    tick();
    req_valid = 2'b00;
    tick();
  endtask

`ifdef ALU_ARB_STATS_EN
  task automatic test_stats();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    req_valid = 2'b11; rsp_ready = 2'b11;
    for (int c = 0; c < 10; c++) tick();
    req_valid = 2'b00;
    tick();
    n_cmp++; if (stat_grants !== {16'd5, 16'd5}) begin n_err++; $display("FAIL stat_grants got=%h exp=00050005", stat_grants); end
    n_cmp++; if (stat_stalls !== 16'd10) begin n_err++; $display("FAIL stat_stalls got=%0d exp=10", stat_stalls); end
    req_valid = 2'b11;
    for (int c = 0; c < 65530; c++) tick();
    req_valid = 2'b00;
    tick();
    n_cmp++; if (stat_stalls !== 16'hFFFF) begin n_err++; $display("FAIL stat_stall_sat got=%h exp=FFFF", stat_stalls); end
    n_cmp++; if (stat_grants !== {16'd32770, 16'd32770}) begin n_err++; $display("FAIL stat_grants_big got=%h exp=80028002", stat_grants); end
  endtask
`else
  task automatic test_stats();
    req_valid = 2'b11; rsp_ready = 2'b11;
    for (int c = 0; c < 4; c++) tick();
    req_valid = 2'b00;
    n_cmp++; if (stat_grants !== 32'd0 || stat_stalls !== 16'd0) begin n_err++; $display("FAIL stat_tied got=%h/%h exp=0/0", stat_grants, stat_stalls); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_reset_mid();
    test_stats();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
